// File: rtl/oram_path_walker_pkg.sv
// Shared types and width helpers for the Path ORAM access sequencer and its
// bucket-index helper.
package oram_path_walker_pkg;

    typedef enum logic [1:0] {
        READ_PATH  = 2'd0,
        WRITE_PATH = 2'd1,
        ACCESS     = 2'd2,
        RSVD       = 2'd3
    } oram_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_TURN,
        ST_WRITE,
        ST_DONE
    } walker_state_t;

    function automatic int levels(input int tree_depth);
        return tree_depth + 1;
    endfunction

    function automatic int num_buckets(input int tree_depth);
        return (1 << levels(tree_depth)) - 1;
    endfunction

    function automatic int tuple_addr_width(input int tree_depth, input int k);
        return $clog2(num_buckets(tree_depth) * k);
    endfunction

    function automatic int level_width(input int tree_depth);
        return (tree_depth < 1) ? 1 : $clog2(tree_depth + 1);
    endfunction

    function automatic int slot_width(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/oram_bucket_index.sv
// Heap index of the bucket at a given level on the path to a leaf:
// node = (2^level - 1) + (leaf >> (TREE_DEPTH - level)).
module oram_bucket_index
    import oram_path_walker_pkg::*;
#(
    parameter int TREE_DEPTH = 12,
    parameter int ADDR_W     = tuple_addr_width(TREE_DEPTH, 3),
    parameter int LVL_W      = level_width(TREE_DEPTH)
) (
    input  logic [TREE_DEPTH-1:0] leaf,
    input  logic [LVL_W-1:0]      level,
    output logic [ADDR_W-1:0]     node
);

    logic [LVL_W-1:0]      shamt;
    logic [TREE_DEPTH-1:0] prefix;

    always_comb begin
        shamt  = LVL_W'(TREE_DEPTH) - level;
        prefix = leaf >> shamt;
        node   = ((ADDR_W'(1) << level) - ADDR_W'(1)) + ADDR_W'(prefix);
    end

endmodule

// File: rtl/oram_path_walker.sv
// Path ORAM access sequencer: walks one root-to-leaf path issuing one tuple
// request per slot, reads root->leaf and evicts leaf->root.
module oram_path_walker
    import oram_path_walker_pkg::*;
#(
    parameter  int TREE_DEPTH = 12,
    parameter  int K          = 3,
    parameter  int ADDR_W     = tuple_addr_width(TREE_DEPTH, K),
    localparam int LVL_W      = level_width(TREE_DEPTH),
    localparam int SLOT_W     = slot_width(K)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [TREE_DEPTH-1:0] leaf,
    input  logic                  evict_go,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_we,
    output logic [ADDR_W-1:0]     req_addr,
    output logic [LVL_W-1:0]      req_level,
    output logic [SLOT_W-1:0]     req_slot,
    output logic                  busy,
    output logic                  done,
    output logic                  start_err
);

    localparam logic [LVL_W-1:0]  LVL_MAX  = LVL_W'(TREE_DEPTH);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(K - 1);
    localparam logic [ADDR_W-1:0] K_A      = ADDR_W'(K);

    walker_state_t         state;
    oram_mode_t            mode_q;
    oram_mode_t            mode_in;
    logic [TREE_DEPTH-1:0] leaf_q;
    logic [TREE_DEPTH-1:0] idx_leaf;
    logic [LVL_W-1:0]      nxt_level;
    logic [SLOT_W-1:0]     nxt_slot;
    logic [ADDR_W-1:0]     node;
    logic [ADDR_W-1:0]     nxt_addr;
    logic                  hs;
    logic                  slot_last;

    assign hs        = req_valid && req_ready;
    assign slot_last = (req_slot == SLOT_MAX);
    assign mode_in   = oram_mode_t'(mode);

    // Position of the request that follows the current one; in IDLE the leaf
    // comes straight from the port so the first request is ready one cycle after start.
    // NOTE: every output gets a default first, so no path through this block infers a latch.
    always_comb begin
        idx_leaf  = leaf_q;
        nxt_level = req_level;
        nxt_slot  = req_slot;
        case (state)
            ST_IDLE: begin
                idx_leaf  = leaf;
                nxt_slot  = '0;
                nxt_level = (mode_in == WRITE_PATH) ? LVL_MAX : '0;
            end
            ST_READ: begin
                if (slot_last) begin
                    nxt_slot  = '0;
                    nxt_level = req_level + LVL_W'(1);
                end else begin
                    nxt_slot = req_slot + SLOT_W'(1);
                end
            end
            ST_WRITE: begin
                if (slot_last) begin
                    nxt_slot  = '0;
                    nxt_level = req_level - LVL_W'(1);
                end else begin
                    nxt_slot = req_slot + SLOT_W'(1);
                end
            end
            ST_TURN: begin
                nxt_slot  = '0;
                nxt_level = LVL_MAX;
            end
            default: ;
        endcase
    end

    oram_bucket_index #(
        .TREE_DEPTH (TREE_DEPTH),
        .ADDR_W     (ADDR_W),
        .LVL_W      (LVL_W)
    ) u_bucket_index (
        .leaf  (idx_leaf),
        .level (nxt_level),
        .node  (node)
    );

    assign nxt_addr = node * K_A + ADDR_W'(nxt_slot);

    // NOTE: all state and registered outputs update with <= so every branch
    // sees the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_q    <= READ_PATH;
            leaf_q    <= '0;
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_level <= '0;
            req_slot  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            start_err <= 1'b0;
        end else begin
            done      <= 1'b0;
            start_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (mode_in == RSVD) begin
                            start_err <= 1'b1;
                        end else begin
                            mode_q    <= mode_in;
                            leaf_q    <= leaf;
                            req_valid <= 1'b1;
                            req_we    <= (mode_in == WRITE_PATH);
                            req_addr  <= nxt_addr;
                            req_level <= nxt_level;
                            req_slot  <= nxt_slot;
                            busy      <= 1'b1;
                            state     <= (mode_in == WRITE_PATH) ? ST_WRITE : ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (hs) begin
                        if (slot_last && req_level == LVL_MAX) begin
                            req_valid <= 1'b0;
                            if (mode_q == ACCESS) begin
                                state <= ST_TURN;
                            end else begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            req_addr  <= nxt_addr;
                            req_level <= nxt_level;
                            req_slot  <= nxt_slot;
                        end
                    end
                end
                ST_TURN: begin
                    if (evict_go) begin
                        req_valid <= 1'b1;
                        req_we    <= 1'b1;
                        req_addr  <= nxt_addr;
                        req_level <= nxt_level;
                        req_slot  <= nxt_slot;
                        state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (hs) begin
                        if (slot_last && req_level == '0) begin
                            req_valid <= 1'b0;
                            state     <= ST_DONE;
                            done      <= 1'b1;
                        end else begin
                            req_addr  <= nxt_addr;
                            req_level <= nxt_level;
                            req_slot  <= nxt_slot;
                        end
                    end
                end
                ST_DONE: begin
                    req_we <= 1'b0;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oram_path_walker.sv
// Bench for oram_path_walker: a default-size instance and a TREE_DEPTH=2/K=2
// instance, both checked every cycle against a path-list reference model.
module tb_oram_path_walker;
    import oram_path_walker_pkg::*;

    localparam int AD = 12, AK = 3, BD = 2, BK = 2;
    localparam int A_AW = tuple_addr_width(AD, AK);
    localparam int A_LW = level_width(AD);
    localparam int A_SW = slot_width(AK);
    localparam int B_AW = tuple_addr_width(BD, BK);
    localparam int B_LW = level_width(BD);
    localparam int B_SW = slot_width(BK);

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] level;
        logic [31:0] slot;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic            a_start = 1'b0, a_evict_go = 1'b0, a_req_ready = 1'b1;
    logic [1:0]      a_mode = 2'd0;
    logic [AD-1:0]   a_leaf = '0;
    logic            a_req_valid, a_req_we, a_busy, a_done, a_start_err;
    logic [A_AW-1:0] a_req_addr;
    logic [A_LW-1:0] a_req_level;
    logic [A_SW-1:0] a_req_slot;

    logic            b_start = 1'b0, b_evict_go = 1'b0, b_req_ready = 1'b1;
    logic [1:0]      b_mode = 2'd0;
    logic [BD-1:0]   b_leaf = '0;
    logic            b_req_valid, b_req_we, b_busy, b_done, b_start_err;
    logic [B_AW-1:0] b_req_addr;
    logic [B_LW-1:0] b_req_level;
    logic [B_SW-1:0] b_req_slot;

    bit   a_rand = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    req_t exp_mem [2][128];
    int   exp_head [2];
    int   exp_tail [2];
    bit   done_due [2];

    oram_path_walker #(.TREE_DEPTH(AD), .K(AK)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .leaf(a_leaf),
        .evict_go(a_evict_go), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .req_addr(a_req_addr), .req_level(a_req_level),
        .req_slot(a_req_slot), .busy(a_busy), .done(a_done), .start_err(a_start_err)
    );

    oram_path_walker #(.TREE_DEPTH(BD), .K(BK)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .leaf(b_leaf),
        .evict_go(b_evict_go), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_addr(b_req_addr), .req_level(b_req_level),
        .req_slot(b_req_slot), .busy(b_busy), .done(b_done), .start_err(b_start_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the list of tuples on the path, in issue order.
    task automatic push_phase(input int i, input int d, input int k, input int leaf, input bit we);
        for (int n = 0; n <= d; n++) begin
            int l = we ? d - n : n;
            for (int s = 0; s < k; s++) begin
                req_t r;
                r.we    = we;
                r.level = l;
                r.slot  = s;
                r.addr  = (((1 << l) - 1) + (leaf >> (d - l))) * k + s;
                exp_mem[i][exp_tail[i]] = r;
                exp_tail[i]++;
            end
        end
    endtask

    task automatic start_access(input int i, input logic [1:0] mode, input int leaf);
        int d = (i == 0) ? AD : BD;
        int k = (i == 0) ? AK : BK;
        exp_head[i] = 0;
        exp_tail[i] = 0;
        if (mode == 2'd0 || mode == 2'd2) push_phase(i, d, k, leaf, 1'b0);
        if (mode == 2'd1 || mode == 2'd2) push_phase(i, d, k, leaf, 1'b1);
        @(posedge clk); #1;
        if (i == 0) begin
            a_start = 1'b1; a_mode = mode; a_leaf = leaf[AD-1:0];
        end else begin
            b_start = 1'b1; b_mode = mode; b_leaf = leaf[BD-1:0];
        end
        @(posedge clk); #1;
        // Scramble mode/leaf after the start cycle: the walker must use its latched copies.
        if (i == 0) begin
            a_start = 1'b0; a_mode = 2'd0; a_leaf = ~a_leaf;
        end else begin
            b_start = 1'b0; b_mode = 2'd0; b_leaf = ~b_leaf;
        end
    endtask

    function automatic logic busy_of(input int i);
        return (i == 0) ? a_busy : b_busy;
    endfunction

    task automatic wait_done(input int i, input int budget);
        bit fin = 1'b0;
        for (int c = 0; c < budget && !fin; c++) begin
            @(posedge clk); #2;
            if (busy_of(i) == 1'b0 && exp_head[i] == exp_tail[i]) fin = 1'b1;
        end
        check($sformatf("finish_busy_%0d", i), busy_of(i), 0);
        check($sformatf("drained_%0d", i), exp_head[i], exp_tail[i]);
    endtask

    task automatic cmp_cycle(input int i, input logic valid, input logic ready, input logic we,
                             input logic [31:0] addr, input logic [31:0] level,
                             input logic [31:0] slot, input logic done);
        req_t e;
        check($sformatf("done_%0d", i), done, done_due[i]);
        done_due[i] = 1'b0;
        if (valid !== 1'b0) begin
            if (exp_head[i] == exp_tail[i]) begin
                check($sformatf("spurious_req_%0d", i), valid, 0);
            end else begin
                e = exp_mem[i][exp_head[i]];
                check($sformatf("we_%0d[%0d]", i, exp_head[i]), we, e.we);
                check($sformatf("addr_%0d[%0d]", i, exp_head[i]), addr, e.addr);
                check($sformatf("level_%0d[%0d]", i, exp_head[i]), level, e.level);
                check($sformatf("slot_%0d[%0d]", i, exp_head[i]), slot, e.slot);
                if (ready === 1'b1) begin
                    exp_head[i]++;
                    if (exp_head[i] == exp_tail[i]) done_due[i] = 1'b1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            cmp_cycle(0, a_req_valid, a_req_ready, a_req_we, 32'(a_req_addr),
                      32'(a_req_level), 32'(a_req_slot), a_done);
            cmp_cycle(1, b_req_valid, b_req_ready, b_req_we, 32'(b_req_addr),
                      32'(b_req_level), 32'(b_req_slot), b_done);
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            a_req_ready = a_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lit_r0 [9] = '{0, 1, 2, 3, 4, 5, 9, 10, 11};
        int lit_b  [12] = '{0, 1, 4, 5, 10, 11, 10, 11, 4, 5, 0, 1};
        int guard;

        exp_head = '{0, 0};
        exp_tail = '{0, 0};
        done_due = '{1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_valid", a_req_valid, 0);
        check("rst_a_we", a_req_we, 0);
        check("rst_a_addr", a_req_addr, 0);
        check("rst_a_level", a_req_level, 0);
        check("rst_a_slot", a_req_slot, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_done", a_done, 0);
        check("rst_a_err", a_start_err, 0);
        check("rst_b_valid", b_req_valid, 0);
        check("rst_b_busy", b_busy, 0);
        rst = 1'b0;

        // Mode 0, leaf 0, always ready
        start_access(0, 2'd0, 0);
        for (int n = 0; n < 9; n++) check("pin_read_leaf0", exp_mem[0][n].addr, lit_r0[n]);
        check("pin_read_leaf0_end0", exp_mem[0][36].addr, 12285);
        check("pin_read_leaf0_end2", exp_mem[0][38].addr, 12287);
        check("pin_read_len", exp_tail[0], 39);
        @(negedge clk);
        check("first_req_latency", a_req_valid, 1);
        check("first_req_busy", a_busy, 1);
        wait_done(0, 200);

        // Mode 1, leaf 4095, with a start pulse mid-walk that must be ignored
        start_access(0, 2'd1, 4095);
        check("pin_write_first", exp_mem[0][0].addr, 24570);
        check("pin_write_first_lvl", exp_mem[0][0].level, 12);
        check("pin_write_last0", exp_mem[0][36].addr, 0);
        check("pin_write_last2", exp_mem[0][38].addr, 2);
        repeat (5) @(posedge clk);
        #1 a_start = 1'b1; a_mode = 2'd0;
        @(posedge clk); #1 a_start = 1'b0;
        wait_done(0, 200);

        // Small tree, ACCESS mode, leaf 2: read, hold in TURN, evict
        start_access(1, 2'd2, 2);
        for (int n = 0; n < 12; n++) check("pin_b_addr", exp_mem[1][n].addr, lit_b[n]);
        guard = 0;
        while (exp_head[1] != 6 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        check("b_read_phase_len", exp_head[1], 6);
        repeat (5) begin
            @(negedge clk);
            check("turn_hold_valid", b_req_valid, 0);
            check("turn_hold_busy", b_busy, 1);
        end
        @(posedge clk); #1 b_evict_go = 1'b1;
        @(posedge clk); #1 b_evict_go = 1'b0;
        wait_done(1, 100);

        // Pseudo-random back-pressure; evict_go held high throughout, including in READ
        a_rand = 1'b1;
        a_evict_go = 1'b1;
        start_access(0, 2'd0, 0);
        wait_done(0, 1000);
        start_access(0, 2'd1, 12'h9C3);
        wait_done(0, 1000);
        start_access(0, 2'd2, 12'h5A3);
        wait_done(0, 2000);
        a_rand = 1'b0;
        a_evict_go = 1'b0;
        repeat (2) @(posedge clk);

        // Reserved mode
        start_access(0, 2'd3, 7);
        @(negedge clk);
        check("err_pulse", a_start_err, 1);
        check("err_busy", a_busy, 0);
        check("err_valid", a_req_valid, 0);
        @(negedge clk);
        check("err_pulse_end", a_start_err, 0);
        check("err_busy_after", a_busy, 0);

        // Reset with the 7th read request on the bus
        start_access(0, 2'd0, 0);
        guard = 0;
        while (exp_head[0] != 7 && guard < 50) begin
            @(negedge clk); #1;
            guard++;
        end
        check("rst_mid_reached", exp_head[0], 7);
        rst = 1'b1;
        exp_head[0] = exp_tail[0];
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", a_req_valid, 0);
        check("rst_mid_busy", a_busy, 0);
        check("rst_mid_done", a_done, 0);
        repeat (3) @(negedge clk);
        start_access(0, 2'd0, 0);
        @(negedge clk);
        check("restart_addr", a_req_addr, 0);
        wait_done(0, 200);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oram_path_walker.md
Name: oram_path_walker

Overview:
- Path ORAM access sequencer.
- Given a leaf label and an access mode, it walks one root-to-leaf path of the bucket tree and issues one tuple request per slot to the tree memory.
- Read phase walks root→leaf; write (eviction) phase walks leaf→root.
- Sits between the ORAM controller (start/done) and the tree storage port; generalises the fixed TREE_DEPTH/K constants into per-instance parameters and adds selectable access modes.

Parameters:
- TREE_DEPTH, 12, leaf label width; tree has TREE_DEPTH+1 levels, 2^TREE_DEPTH leaves.
- K, 3, tuples (slots) per bucket, ≥1.
- ADDR_W, $clog2((2^(TREE_DEPTH+1)-1)*K), tuple address width (15 at defaults).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request an access; sampled only in IDLE.
- mode  in  2  0=READ_PATH, 1=WRITE_PATH, 2=ACCESS (read then write), 3=reserved.
- leaf  in  TREE_DEPTH  target leaf; captured with start.
- evict_go  in  1  stash ready to supply eviction data (ACCESS mode only).
- req_valid  out  1  tuple request valid.
- req_ready  in  1  memory accepts request.
- req_we  out  1  0=read, 1=write.
- req_addr  out  ADDR_W  tuple address = node*K + slot.
- req_level  out  $clog2(TREE_DEPTH+1)  level of the current bucket (0=root).
- req_slot  out  $clog2(K) (min 1)  slot within the bucket.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of access.
- start_err  out  1  one-cycle pulse when start arrives with mode=3.

Behaviour:
- Reset: state=IDLE. All outputs 0: req_valid, req_we, req_addr, req_level, req_slot, busy, done, start_err. The internal leaf register also clears.
- Node index (0-based heap): node(l) = (2^l − 1) + (leaf >> (TREE_DEPTH − l)), for l in 0..TREE_DEPTH.
- Widths: node computed at ADDR_W bits; node*K+slot must not overflow ADDR_W.
- States: IDLE, READ, TURN, WRITE, DONE.
- IDLE:
  - start & mode∈{0,2} → READ, level=0, slot=0.
  - start & mode=1 → WRITE, level=TREE_DEPTH, slot=0.
  - start & mode=3 → start_err pulse next cycle; remain IDLE.
  - leaf and mode are latched on an accepted start.
- READ:
  - req_valid=1, req_we=0.
  - Each handshake (req_valid & req_ready) advances slot. slot wraps K−1→0 and increments level.
  - Handshake at level=TREE_DEPTH, slot=K−1: mode 0 → DONE; mode 2 → TURN.
- TURN:
  - req_valid=0.
  - Wait for evict_go; on evict_go → WRITE, level=TREE_DEPTH, slot=0.
  - evict_go outside TURN is ignored.
- WRITE:
  - req_valid=1, req_we=1.
  - Slot advances per handshake; slot wrap decrements level.
  - Handshake at level=0, slot=K−1 → DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 is seen in the cycle after the done pulse.
- Handshake rules:
  - While req_valid=1 and req_ready=0, req_addr/we/level/slot are held stable.
  - req_valid never drops without a handshake, except on rst.
- Latency:
  - With req_ready tied high, the first request appears the cycle after start.
  - One request per cycle; (TREE_DEPTH+1)*K requests per phase.
  - done is asserted the cycle after the last handshake.
  - Mode 2 adds the TURN cycle(s).
- start while busy is ignored; no queuing.
- rst mid-operation: next cycle IDLE, req_valid=0, no done pulse. The in-flight request is abandoned.

Decomposition:
- common_defs_pkg additions:
  - oram_mode_t enum: READ_PATH, WRITE_PATH, ACCESS, RSVD.
  - walker_state_t enum.
  - Derived constants: LEVELS = TREE_DEPTH+1, NUM_BUCKETS = 2^LEVELS − 1, TUPLE_ADDR_WIDTH.
- Sub-module oram_bucket_index: combinational (leaf, level) → node index, parametrised on TREE_DEPTH. It is reused by the stash eviction logic.

Test Plan:
- Defaults, mode=0, leaf=0, req_ready=1 → 39 reads:
  - addr sequence 0,1,2,3,4,5,9,10,11, … ending 12285,12286,12287;
  - done on the cycle after the 39th handshake.
- Defaults, mode=1, leaf=4095, req_ready=1 → 39 writes:
  - first addr 24570,24571,24572 (node 8190, level 12);
  - last addr 0,1,2 (root).
- TREE_DEPTH=2, K=2, mode=2, leaf=2'b10:
  - read addrs 0,1,4,5,10,11;
  - hold in TURN for 5 cycles with evict_go=0;
  - after evict_go, write addrs 10,11,4,5,0,1, then done.
- req_ready toggled pseudo-randomly → addr/we/level/slot stable while stalled; handshake count and sequence identical to the req_ready=1 run.
- start with mode=3 → start_err=1 for one cycle; busy stays 0; no req_valid.
- Assert rst at the 7th request of mode 0 → next cycle req_valid=0, busy=0, no done pulse; a fresh start then proceeds normally from addr 0.
